video_oam_ctrl: RTL and testbench

VIDEO_OAM_CTRL -- requirements
Module: video_oam_ctrl

---
 rtl/video_oam_ctrl_if.sv | 25 ++
 rtl/video_oam_ctrl.sv | 132 +++++++++++++
 tb/tb_video_oam_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_oam_ctrl_if.sv
// DMA source-bus handshake for the OAM controller: request/address out, ack/data back.
// The controller uses the master modport; the memory/bus side uses slave.
interface video_oam_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic                  I_dma_ack;
   logic [DATA_W-1:0]     I_dma_data;
   logic                  O_dma_req;
   logic [8+ADDR_W-1:0]   O_dma_addr;

   modport master (
      input  I_dma_ack,
      input  I_dma_data,
      output O_dma_req,
      output O_dma_addr
   );

   modport slave (
      output I_dma_ack,
      output I_dma_data,
      input  O_dma_req,
      input  O_dma_addr
   );
endinterface

// File: rtl/video_oam_ctrl.sv
// Sprite attribute memory with a CPU address/data port, a page-copy DMA engine
// and a registered renderer read port.
module video_oam_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int ATTR_MASK = 1
) (
   input  logic              I_clock,
   input  logic              I_reset,
   input  logic              I_addr_wren,
   input  logic              I_addr_clr,
   input  logic              I_data_wren,
   input  logic              I_dma_start,
   input  logic [DATA_W-1:0] I_data,
   input  logic [ADDR_W-1:0] I_rd_addr,
   output logic [DATA_W-1:0] O_rd_data,
   output logic [ADDR_W-1:0] O_addr,
   output logic [DATA_W-1:0] O_data,
   output logic              O_dma_busy,
   video_oam_ctrl_if.master  dma
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HALT,
      ST_READ,
      ST_WRITE
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        page_q, page_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] oam_addr_q, oam_addr_d;
   logic [DATA_W-1:0] dma_byte_q, dma_byte_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] cpu_view;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      count_d    = count_q;
      oam_addr_d = oam_addr_q;
      dma_byte_d = dma_byte_q;
      mem_we     = 1'b0;
      mem_wd     = I_data;

      unique case (state_q)
         ST_IDLE: begin
            if (!I_addr_clr) begin
               if (I_dma_start) begin
                  page_d  = I_data[7:0];
                  count_d = '0;
                  state_d = ST_HALT;
               end else if (I_addr_wren) begin
                  oam_addr_d = I_data[ADDR_W-1:0];
               end else if (I_data_wren) begin
                  mem_we     = 1'b1;
                  oam_addr_d = oam_addr_q + 1'b1;
               end
            end
         end
         ST_HALT: state_d = ST_READ;
         ST_READ: begin
            if (dma.I_dma_ack) begin
               dma_byte_d = dma.I_dma_data;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we     = 1'b1;
            mem_wd     = dma_byte_q;
            oam_addr_d = oam_addr_q + 1'b1;
            count_d    = count_q + 1'b1;
            state_d    = (&count_q) ? ST_IDLE : ST_READ;
         end
         default: state_d = ST_IDLE;
      endcase

      // A clear racing a DMA write lands after that write's increment, so copying resumes at 1.
      if (I_addr_clr) begin
         oam_addr_d = (state_q == ST_WRITE) ? ADDR_W'(1) : '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge I_clock) begin
      if (!I_reset) begin
         state_q    <= ST_IDLE;
         page_q     <= '0;
         count_q    <= '0;
         oam_addr_q <= '0;
         dma_byte_q <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         count_q    <= count_d;
         oam_addr_q <= oam_addr_d;
         dma_byte_q <= dma_byte_d;
         rd_data_q  <= mem_q[I_rd_addr];
      end
   end

   // NOTE: the array has no reset so it maps to RAM; a reset edge only suppresses the write.
   always_ff @(posedge I_clock) begin
      if (mem_we && I_reset) begin
         mem_q[oam_addr_q] <= mem_wd;
      end
   end

   always_comb begin
      cpu_view = mem_q[oam_addr_q];
      if ((ATTR_MASK != 0) && (oam_addr_q[1:0] == 2'd2)) begin
         cpu_view[4:2] = 3'b000;
      end
   end

   assign O_data         = cpu_view;
   assign O_rd_data      = rd_data_q;
   assign O_addr         = oam_addr_q;
   assign O_dma_busy     = (state_q != ST_IDLE);
   assign dma.O_dma_req  = (state_q == ST_READ);
   assign dma.O_dma_addr = {page_q, count_q};

endmodule

// File: tb/tb_video_oam_ctrl.sv
// Directed bench for video_oam_ctrl: CPU port, attribute masking, renderer port,
// DMA with fast and slow acknowledge, clear and reset during a transfer.
module tb_video_oam_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       addr_wren, addr_clr, data_wren, dma_start;
   logic [7:0] data, rd_addr;
   logic [7:0] rd_data, o_addr, o_data;
   logic       busy;
   logic [7:0] dma_key;
   int         ack_mode;
   int         wait_cnt;
   int         n_tests = 0;
   int         n_fail  = 0;

   video_oam_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   video_oam_ctrl #(.ADDR_W(8), .DATA_W(8), .ATTR_MASK(1)) dut (
      .I_clock     (clk),
      .I_reset     (rst_n),
      .I_addr_wren (addr_wren),
      .I_addr_clr  (addr_clr),
      .I_data_wren (data_wren),
      .I_dma_start (dma_start),
      .I_data      (data),
      .I_rd_addr   (rd_addr),
      .O_rd_data   (rd_data),
      .O_addr      (o_addr),
      .O_data      (o_data),
      .O_dma_busy  (busy),
      .dma         (bus.master)
   );

   always #5 clk = ~clk;

   // Source memory model: each source byte is its low address XOR a per-test key.
   assign bus.I_dma_data = bus.O_dma_addr[7:0] ^ dma_key;

   // Ack responder: 0 = never, 1 = tied high, 2 = three wait cycles per request.
   always @(negedge clk) begin
      if (ack_mode == 1) begin
         bus.I_dma_ack = 1'b1;
      end else if (ack_mode == 2 && bus.O_dma_req) begin
         if (wait_cnt == 3) begin
            bus.I_dma_ack = 1'b1;
            wait_cnt      = 0;
         end else begin
            bus.I_dma_ack = 1'b0;
            wait_cnt      = wait_cnt + 1;
         end
      end else begin
         bus.I_dma_ack = 1'b0;
         wait_cnt      = 0;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_set_addr(input logic [7:0] a);
      addr_wren = 1'b1; data = a;
      step();
      addr_wren = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] d);
      data_wren = 1'b1; data = d;
      step();
      data_wren = 1'b0;
   endtask

   task automatic rd_mem(input logic [7:0] a, output logic [7:0] d);
      rd_addr = a;
      step();
      d = rd_data;
   endtask

   task automatic start_dma(input logic [7:0] page);
      dma_start = 1'b1; data = page;
      step();
      dma_start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(2);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_tests++; if (bus.O_dma_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", bus.O_dma_req); end
      n_tests++; if (o_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", o_addr); end
      n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_cpu_write;
      logic [7:0] d;
      cpu_set_addr(8'h10);
      for (int i = 0; i < 4; i++) cpu_write(8'hA0 + 8'(i));
      n_tests++; if (o_addr !== 8'h14) begin n_fail++; $display("FAIL cpu_addr_inc got %h want 14", o_addr); end
      for (int i = 0; i < 4; i++) begin
         rd_mem(8'h10 + 8'(i), d);
         n_tests++; if (d !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL cpu_mem[%0d] got %h want %h", i, d, 8'hA0 + 8'(i)); end
      end
   endtask

   task automatic test_attr_mask;
      logic [7:0] d;
      cpu_set_addr(8'h02);
      cpu_write(8'hFF);
      cpu_set_addr(8'h02);
      n_tests++; if (o_data !== 8'hE3) begin n_fail++; $display("FAIL attr_masked got %h want e3", o_data); end
      rd_mem(8'h02, d);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL attr_rd_unmasked got %h want ff", d); end
      cpu_set_addr(8'h10);
      n_tests++; if (o_data !== 8'hA0) begin n_fail++; $display("FAIL attr_unmasked_slot got %h want a0", o_data); end
   endtask

   task automatic test_priority;
      logic [7:0] d;
      cpu_set_addr(8'h30);
      cpu_write(8'h77); cpu_write(8'h66); cpu_write(8'h55); cpu_write(8'h44);
      cpu_set_addr(8'h33);
      // Address load beats data write.
      addr_wren = 1'b1; data_wren = 1'b1; data = 8'h30;
      step();
      addr_wren = 1'b0; data_wren = 1'b0;
      n_tests++; if (o_addr !== 8'h30) begin n_fail++; $display("FAIL prio_wren_addr got %h want 30", o_addr); end
      n_tests++; if (o_data !== 8'h77) begin n_fail++; $display("FAIL prio_wren_data got %h want 77", o_data); end
      rd_mem(8'h33, d);
      n_tests++; if (d !== 8'h44) begin n_fail++; $display("FAIL prio_no_write got %h want 44", d); end
      // Clear beats DMA start and address load.
      addr_clr = 1'b1; dma_start = 1'b1; addr_wren = 1'b1; data = 8'h55;
      step();
      addr_clr = 1'b0; dma_start = 1'b0; addr_wren = 1'b0;
      n_tests++; if (o_addr !== 8'h00) begin n_fail++; $display("FAIL prio_clr_addr got %h want 00", o_addr); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_clr_no_dma got %0b want 0", busy); end
   endtask

   task automatic test_rd_same_cycle;
      cpu_set_addr(8'h40);
      cpu_write(8'h12);
      cpu_set_addr(8'h40);
      rd_addr = 8'h40; data_wren = 1'b1; data = 8'h34;
      step();
      data_wren = 1'b0;
      n_tests++; if (rd_data !== 8'h12) begin n_fail++; $display("FAIL rd_old_data got %h want 12", rd_data); end
      step();
      n_tests++; if (rd_data !== 8'h34) begin n_fail++; $display("FAIL rd_new_data got %h want 34", rd_data); end
   endtask

   task automatic test_dma_full;
      int cyc;
      logic [7:0] d;
      cpu_set_addr(8'hFE);
      dma_key = 8'h00; ack_mode = 1;
      start_dma(8'h02);
      n_tests++; if (bus.O_dma_addr !== 16'h0200) begin n_fail++; $display("FAIL full_dma_addr got %h want 0200", bus.O_dma_addr); end
      cyc = 0;
      while (busy === 1'b1 && cyc < 2000) begin cyc++; step(); end
      ack_mode = 0;
      n_tests++; if (cyc !== 513) begin n_fail++; $display("FAIL full_busy_cycles got %0d want 513", cyc); end
      n_tests++; if (o_addr !== 8'hFE) begin n_fail++; $display("FAIL full_end_addr got %h want fe", o_addr); end
      rd_mem(8'hFE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL full_mem_fe got %h want 00", d); end
      rd_mem(8'hFF, d);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL full_mem_ff got %h want 01", d); end
      rd_mem(8'h00, d);
      n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL full_mem_00 got %h want 02", d); end
   endtask

   task automatic test_dma_delayed;
      int cyc, addr_err, req_cyc;
      logic [7:0] exp_cnt, d;
      logic prev_req;
      cpu_set_addr(8'h00);
      dma_key = 8'h5A; ack_mode = 2;
      start_dma(8'h03);
      cyc = 0; addr_err = 0; req_cyc = 0; exp_cnt = 8'h00; prev_req = 1'b0;
      while (busy === 1'b1 && cyc < 5000) begin
         if (bus.O_dma_req === 1'b1) begin
            req_cyc++;
            if (bus.O_dma_addr !== {8'h03, exp_cnt}) addr_err++;
         end else if (prev_req) begin
            exp_cnt++;
         end
         prev_req = bus.O_dma_req;
         // CPU writes and a second start arrive mid-transfer and must be ignored.
         if (cyc == 20) begin dma_start = 1'b1; addr_wren = 1'b1; data_wren = 1'b1; data = 8'h07; end
         if (cyc == 21) begin dma_start = 1'b0; addr_wren = 1'b0; data_wren = 1'b0; end
         cyc++;
         step();
      end
      ack_mode = 0;
      n_tests++; if (cyc !== 1281) begin n_fail++; $display("FAIL slow_busy_cycles got %0d want 1281", cyc); end
      n_tests++; if (addr_err !== 0) begin n_fail++; $display("FAIL slow_req_addr_stable got %0d bad cycles want 0", addr_err); end
      n_tests++; if (req_cyc !== 1024) begin n_fail++; $display("FAIL slow_req_cycles got %0d want 1024", req_cyc); end
      n_tests++; if (o_addr !== 8'h00) begin n_fail++; $display("FAIL slow_end_addr got %h want 00", o_addr); end
      rd_mem(8'h00, d);
      n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL slow_mem_00 got %h want 5a", d); end
      rd_mem(8'h0A, d);
      n_tests++; if (d !== 8'h50) begin n_fail++; $display("FAIL slow_mem_0a got %h want 50", d); end
      rd_mem(8'hFF, d);
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL slow_mem_ff got %h want a5", d); end
   endtask

   task automatic test_clr_mid_dma;
      logic [7:0] d;
      cpu_set_addr(8'h80);
      dma_key = 8'h00; ack_mode = 1;
      start_dma(8'h01);                // now in HALT
      step(2);                         // now in WRITE of byte 0
      n_tests++; if (busy !== 1'b1 || bus.O_dma_req !== 1'b0) begin n_fail++; $display("FAIL clr_in_write got busy=%0b req=%0b want 1/0", busy, bus.O_dma_req); end
      addr_clr = 1'b1;
      step();
      addr_clr = 1'b0;
      n_tests++; if (o_addr !== 8'h01) begin n_fail++; $display("FAIL clr_resume_addr got %h want 01", o_addr); end
      step(4);                         // bytes 1 and 2 written, READ of byte 3
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ack_mode = 0;
      n_tests++; if (busy !== 1'b0 || o_addr !== 8'h00) begin n_fail++; $display("FAIL clr_abort got busy=%0b addr=%h want 0/00", busy, o_addr); end
      rd_mem(8'h80, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL clr_mem_80 got %h want 00", d); end
      rd_mem(8'h01, d);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL clr_mem_01 got %h want 01", d); end
      rd_mem(8'h02, d);
      n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL clr_mem_02 got %h want 02", d); end
      rd_mem(8'h03, d);
      n_tests++; if (d !== 8'h59) begin n_fail++; $display("FAIL clr_mem_03 got %h want 59", d); end
   endtask

   task automatic test_reset_mid_dma;
      logic [7:0] d;
      cpu_set_addr(8'h00);
      dma_key = 8'hC0; ack_mode = 1;
      start_dma(8'h04);                // HALT
      step(11);                        // READ with count 5
      n_tests++; if (bus.O_dma_addr !== 16'h0405) begin n_fail++; $display("FAIL rst_pre_addr got %h want 0405", bus.O_dma_addr); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ack_mode = 0;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_dma_busy got %0b want 0", busy); end
      n_tests++; if (bus.O_dma_req !== 1'b0) begin n_fail++; $display("FAIL rst_dma_req got %0b want 0", bus.O_dma_req); end
      n_tests++; if (o_addr !== 8'h00) begin n_fail++; $display("FAIL rst_dma_oam_addr got %h want 00", o_addr); end
      n_tests++; if (bus.O_dma_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_dma_addr got %h want 0000", bus.O_dma_addr); end
      rd_mem(8'h00, d);
      n_tests++; if (d !== 8'hC0) begin n_fail++; $display("FAIL rst_mem_00 got %h want c0", d); end
      rd_mem(8'h01, d);
      n_tests++; if (d !== 8'hC1) begin n_fail++; $display("FAIL rst_mem_01 got %h want c1", d); end
      rd_mem(8'h04, d);
      n_tests++; if (d !== 8'hC4) begin n_fail++; $display("FAIL rst_mem_04 got %h want c4", d); end
      rd_mem(8'h05, d);
      n_tests++; if (d !== 8'h5F) begin n_fail++; $display("FAIL rst_mem_05 got %h want 5f", d); end
   endtask

   initial begin
      rst_n = 1'b0; addr_wren = 1'b0; addr_clr = 1'b0; data_wren = 1'b0; dma_start = 1'b0;
      data = 8'h00; rd_addr = 8'h00; dma_key = 8'h00; ack_mode = 0; wait_cnt = 0;
      bus.I_dma_ack = 1'b0;
      step();
      test_reset();
      test_cpu_write();
      test_attr_mask();
      test_priority();
      test_rd_same_cycle();
      test_dma_full();
      test_dma_delayed();
      test_clr_mid_dma();
      test_reset_mid_dma();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
